// File: rtl/img_pkg.sv
// Shared frame geometry and counter types for the 3x3 window generator.
`default_nettype none

package img_pkg;

    localparam int IMG_W         = 320;
    localparam int IMG_H         = 240;
    localparam int DW            = 8;
    localparam int COL_W         = 9;
    localparam int ROW_W         = 8;
    localparam int WIN_PER_FRAME = (IMG_W - 2) * (IMG_H - 2);

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

endpackage

`default_nettype wire

// File: rtl/window_3x3_gen_line_buffer.sv
// Two-row line buffer: one {row r-2, row r-1} word per column, read-before-write.
`default_nettype none

module line_buffer
    import img_pkg::*;
#(
    parameter int DEPTH = img_pkg::IMG_W,
    parameter int AW    = img_pkg::COL_W,
    parameter int W     = 2 * img_pkg::DW
) (
    input  logic          clk_i,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Read is combinational on the current address, so the old word is seen before the edge writes.
    assign rd_data = mem[addr];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator feeding the median filter; one window per interior pixel.
`default_nettype none

module window_3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_W = img_pkg::IMG_W,
    parameter int IMG_H = img_pkg::IMG_H,
    parameter int DW    = img_pkg::DW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DW-1:0]    pix_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    output logic [DW-1:0]    win_o_0,
    output logic [DW-1:0]    win_o_1,
    output logic [DW-1:0]    win_o_2,
    output logic [DW-1:0]    win_o_3,
    output logic [DW-1:0]    win_o_4,
    output logic [DW-1:0]    win_o_5,
    output logic [DW-1:0]    win_o_6,
    output logic [DW-1:0]    win_o_7,
    output logic [DW-1:0]    win_o_8,
    output logic             win_valid_o,
    input  logic             win_ready_i,
    output logic [ROW_W-1:0] win_row_o,
    output logic [COL_W-1:0] win_col_o,
    output logic             frame_done_o
);

    col_t          col;
    row_t          row;
    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          win_ok;
    logic [DW-1:0] lb_a;
    logic [DW-1:0] lb_b;
    logic [DW-1:0] new_col [3];
    logic [DW-1:0] col1    [3];
    logic [DW-1:0] col2    [3];
    logic [DW-1:0] win     [9];

    assign pix_ready_o = !win_valid_o || win_ready_i;
    assign accept      = pix_valid_i && pix_ready_o;
    assign last_col    = (col == COL_W'(IMG_W - 1));
    assign last_row    = (row == ROW_W'(IMG_H - 1));
    assign win_ok      = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    line_buffer #(
        .DEPTH (IMG_W),
        .AW    (COL_W),
        .W     (2 * DW)
    ) u_line_buffer (
        .clk_i   (clk_i),
        .wr_en   (accept),
        .addr    (col),
        .wr_data ({lb_a, pix_i}),
        .rd_data ({lb_b, lb_a})
    );

    // Index 0 is the oldest row (r-2), index 2 the incoming pixel row r.
    assign new_col[0] = lb_b;
    assign new_col[1] = lb_a;
    assign new_col[2] = pix_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            col          <= '0;
            row          <= '0;
            win_valid_o  <= 1'b0;
            win_row_o    <= '0;
            win_col_o    <= '0;
            frame_done_o <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                col1[k] <= '0;
                col2[k] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else begin
            frame_done_o <= accept && last_col && last_row;
            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
                for (int k = 0; k < 3; k++) begin
                    col2[k] <= col1[k];
                    col1[k] <= new_col[k];
                end
                // Edge pixels clear the output so a window never straddles a row or frame seam.
                if (win_ok) begin
                    win_valid_o <= 1'b1;
                    win_row_o   <= row - ROW_W'(1);
                    win_col_o   <= col - COL_W'(1);
                    for (int k = 0; k < 3; k++) begin
                        win[3*k]   <= col2[k];
                        win[3*k+1] <= col1[k];
                        win[3*k+2] <= new_col[k];
                    end
                end else begin
                    win_valid_o <= 1'b0;
                end
            end else if (win_ready_i) begin
                win_valid_o <= 1'b0;
            end
        end
    end

    assign win_o_0 = win[0];
    assign win_o_1 = win[1];
    assign win_o_2 = win[2];
    assign win_o_3 = win[3];
    assign win_o_4 = win[4];
    assign win_o_5 = win[5];
    assign win_o_6 = win[6];
    assign win_o_7 = win[7];
    assign win_o_8 = win[8];

endmodule

`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
// Directed bench: full-size instance for window/backpressure/reset cases, small instance for whole frames.
`default_nettype none

module tb_window_3x3_gen;

    localparam int WA = 320;
    localparam int HA = 240;
    localparam int WB = 8;
    localparam int HB = 5;

    typedef struct {
        int row;
        int col;
        bit inv;
    } exp_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [7:0] pix_a, pix_b;
    logic       pv_a, pv_b;
    logic       prdy_a, prdy_b;
    logic [7:0] wa [9];
    logic [7:0] wb [9];
    logic       wv_a, wv_b;
    logic       wr_a, wr_b;
    logic [7:0] row_a, row_b;
    logic [8:0] col_a, col_b;
    logic       fd_a, fd_b;

    window_3x3_gen #(.IMG_W(WA), .IMG_H(HA), .DW(8)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .pix_i(pix_a), .pix_valid_i(pv_a), .pix_ready_o(prdy_a),
        .win_o_0(wa[0]), .win_o_1(wa[1]), .win_o_2(wa[2]), .win_o_3(wa[3]), .win_o_4(wa[4]),
        .win_o_5(wa[5]), .win_o_6(wa[6]), .win_o_7(wa[7]), .win_o_8(wa[8]),
        .win_valid_o(wv_a), .win_ready_i(wr_a), .win_row_o(row_a), .win_col_o(col_a),
        .frame_done_o(fd_a)
    );

    window_3x3_gen #(.IMG_W(WB), .IMG_H(HB), .DW(8)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .pix_i(pix_b), .pix_valid_i(pv_b), .pix_ready_o(prdy_b),
        .win_o_0(wb[0]), .win_o_1(wb[1]), .win_o_2(wb[2]), .win_o_3(wb[3]), .win_o_4(wb[4]),
        .win_o_5(wb[5]), .win_o_6(wb[6]), .win_o_7(wb[7]), .win_o_8(wb[8]),
        .win_valid_o(wv_b), .win_ready_i(wr_b), .win_row_o(row_b), .win_col_o(col_b),
        .frame_done_o(fd_b)
    );

    int   errors = 0;
    int   checks = 0;
    int   sel    = 0;
    int   cw     = WA;
    int   ch     = HA;
    int   r      = 0;
    int   c      = 0;
    bit   inv    = 1'b0;
    bit   done_exp = 1'b0;
    int   done_cnt = 0;
    int   winc   = 0;
    exp_t expq[$];

    function automatic logic [7:0] pv(input int rr, input int cc, input bit iv, input int w);
        int v;
        v = (rr * w + cc) % 256;
        return iv ? 8'(255 - v) : 8'(v);
    endfunction

    function automatic logic [7:0] tap(input int k);
        return (sel == 1) ? wb[k] : wa[k];
    endfunction

    function automatic logic cur_valid();
        return (sel == 1) ? wv_b : wv_a;
    endfunction

    function automatic logic cur_ready();
        return (sel == 1) ? prdy_b : prdy_a;
    endfunction

    function automatic logic [31:0] cur_row();
        return (sel == 1) ? 32'(row_b) : 32'(row_a);
    endfunction

    function automatic logic [31:0] cur_col();
        return (sel == 1) ? 32'(col_b) : 32'(col_a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input logic v, input logic [7:0] p, input logic rdy, output bit acc);
        exp_t e;
        if (sel == 1) begin
            pv_b = v; pix_b = p; wr_b = rdy;
        end else begin
            pv_a = v; pix_a = p; wr_a = rdy;
        end
        #1;
        if (cur_valid() && rdy) begin
            if (expq.size() == 0) begin
                check("spurious_window", 32'(1), 32'(0));
            end else begin
                e = expq.pop_front();
                winc++;
                check("win_row", cur_row(), 32'(e.row));
                check("win_col", cur_col(), 32'(e.col));
                for (int k = 0; k < 9; k++) begin
                    check($sformatf("tap%0d r%0d c%0d", k, e.row, e.col), 32'(tap(k)),
                          32'(pv(e.row - 1 + k / 3, e.col - 1 + k % 3, e.inv, cw)));
                end
            end
        end
        if (sel == 1) begin
            check("frame_done", 32'(fd_b), 32'(done_exp));
            if (fd_b) done_cnt++;
        end
        acc = v && cur_ready();
        done_exp = 1'b0;
        if (acc) begin
            if (r >= 2 && c >= 2) expq.push_back('{r - 1, c - 1, inv});
            if (c == cw - 1) begin
                c = 0;
                if (r == ch - 1) begin
                    r = 0;
                    done_exp = 1'b1;
                end else begin
                    r++;
                end
            end else begin
                c++;
            end
        end
        @(negedge clk);
    endtask

    task automatic send();
        bit acc;
        int n;
        logic [7:0] p;
        p = pv(r, c, inv, cw);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            tick(1'b1, p, 1'b1, acc);
            n++;
        end
        if (!acc) check("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic stream_to(input int rr, input int cc);
        int guard;
        guard = 0;
        while (!(r == rr && c == cc) && guard < 90000) begin
            send();
            guard++;
        end
    endtask

    task automatic check_first_window(input string pfx);
        logic [7:0] gold [9];
        gold = '{8'd0, 8'd1, 8'd2, 8'd64, 8'd65, 8'd66, 8'd128, 8'd129, 8'd130};
        check({pfx, "_valid"}, 32'(wv_a), 32'(1));
        check({pfx, "_row"}, 32'(row_a), 32'(1));
        check({pfx, "_col"}, 32'(col_a), 32'(1));
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s_tap%0d", pfx, k), 32'(wa[k]), 32'(gold[k]));
        end
    endtask

    initial begin
        bit acc;
        rst_a = 1'b0; rst_b = 1'b0;
        pix_a = '0; pix_b = '0; pv_a = 1'b0; pv_b = 1'b0; wr_a = 1'b1; wr_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(wv_a), 32'(0));
        check("rst_ready", 32'(prdy_a), 32'(1));
        check("rst_row", 32'(row_a), 32'(0));
        check("rst_col", 32'(col_a), 32'(0));
        check("rst_tap0", 32'(wa[0]), 32'(0));
        check("rst_done", 32'(fd_a), 32'(0));
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        // Ramp frame on the full-size instance.
        stream_to(2, 2);
        send();
        check_first_window("first");

        stream_to(3, 0);
        send();
        check("row3_c0_valid", 32'(wv_a), 32'(0));
        send();
        check("row3_c1_valid", 32'(wv_a), 32'(0));
        check("row2_windows", 32'(winc), 32'(318));
        send();
        check("row3_c2_valid", 32'(wv_a), 32'(1));
        check("row3_c2_tap0", 32'(wa[0]), 32'(64));
        check("row3_c2_col", 32'(col_a), 32'(1));

        stream_to(3, 11);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, pv(3, 11, 1'b0, WA), 1'b0, acc);
            check("stall_ready", 32'(prdy_a), 32'(0));
            check("stall_valid", 32'(wv_a), 32'(1));
            check("stall_col", 32'(col_a), 32'(9));
            check("stall_tap0", 32'(wa[0]), 32'(pv(1, 8, 1'b0, WA)));
            check("stall_tap8", 32'(wa[8]), 32'(pv(3, 10, 1'b0, WA)));
        end

        stream_to(100, 50);
        send();
        pv_a = 1'b0;
        #2;
        rst_a = 1'b0;
        #1;
        check("midrst_valid", 32'(wv_a), 32'(0));
        check("midrst_col", 32'(col_a), 32'(0));
        check("midrst_ready", 32'(prdy_a), 32'(1));
        expq.delete();
        r = 0; c = 0;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        stream_to(2, 2);
        send();
        check_first_window("after_rst");
        tick(1'b0, 8'd0, 1'b1, acc);
        check("a_queue_empty", 32'(expq.size()), 32'(0));

        // Back-to-back frames on the small instance: ramp then inverted ramp.
        sel = 1; cw = WB; ch = HB; r = 0; c = 0; inv = 1'b0;
        winc = 0; done_cnt = 0; done_exp = 1'b0;
        repeat (WB * HB) send();
        check("b_frame1_wrap", 32'(r * 100 + c), 32'(0));
        inv = 1'b1;
        stream_to(2, 2);
        send();
        check("b_f2_first_valid", 32'(wv_b), 32'(1));
        check("b_f2_first_tap0", 32'(wb[0]), 32'(255));
        send();
        stream_to(0, 0);
        tick(1'b0, 8'd0, 1'b1, acc);
        tick(1'b0, 8'd0, 1'b1, acc);
        check("b_window_count", 32'(winc), 32'(2 * (WB - 2) * (HB - 2)));
        check("b_done_pulses", 32'(done_cnt), 32'(2));
        check("b_queue_empty", 32'(expq.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the median filter (medyan).
- Accepts raster-order pixels of a 320x240 8-bit frame, one per accepted beat.
- Buffers the two previous rows in line buffers.
- Presents each fully-interior 3x3 window on nine parallel outputs in the median's data_i_0..8 ordering, with a valid/ready handshake toward the filter.

Parameters:
- IMG_W, 320, pixels per row
- IMG_H, 240, rows per frame
- DW, 8, pixel width in bits

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- pix_i  in  DW  input pixel, raster order, row 0 col 0 first
- pix_valid_i  in  1  pix_i valid this cycle
- pix_ready_o  out  1  block accepts pix_i this cycle
- win_o_0..win_o_8  out  DW each  window taps, row-major: 0=(r-2,c-2) 1=(r-2,c-1) 2=(r-2,c) 3=(r-1,c-2) ... 8=(r,c)
- win_valid_o  out  1  window taps valid
- win_ready_i  in  1  downstream (median en/done wrapper) takes window
- win_row_o  out  8  r-1 = centre row of presented window
- win_col_o  out  9  c-1 = centre column of presented window
- frame_done_o  out  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (rst_i low, async): row/col counters 0; win_valid_o 0; win_o_*, win_row_o, win_col_o 0; frame_done_o 0; window regs 0. Line-buffer contents are not cleared; they are don't-care because rows 0-1 never produce windows.
- Accept = pix_valid_i && pix_ready_o.
- pix_ready_o = !win_valid_o || win_ready_i (combinational). Output is a single-entry register.
- On accept at (r,c):
  - Read lbA[c] (row r-1) and lbB[c] (row r-2), read-before-write, same cycle.
  - Write lbB[c] <= lbA[c], lbA[c] <= pix_i.
  - Shift window columns left; new right column = {lbB[c], lbA[c], pix_i}.
- Window valid iff r>=2 && c>=2. On such an accept, next edge loads win_o_* from window cols 1,2 plus the new column, and sets win_valid_o=1. Latency: 1 cycle from accept to valid.
- Accept with r<2 or c<2: win_valid_o cleared if win_ready_i (or already 0). No stale window is ever presented across a row boundary.
- Output hold: while win_valid_o && !win_ready_i, all win_* are stable and no pixel is accepted.
- win_valid_o && win_ready_i with no new accept: win_valid_o -> 0 next cycle.
- Counters: c increments per accept; at c=IMG_W-1, c->0 and r++. At (IMG_H-1, IMG_W-1), r->0 and c->0, and frame_done_o pulses the following cycle. The next frame starts immediately.
- Windows per frame: (IMG_W-2)*(IMG_H-2) = 75684, i.e. 318 per interior row.
- No arithmetic beyond counters. Counter widths: col 9 bits, row 8 bits, with no overflow past IMG_W/IMG_H.
- Reset mid-frame: counters return to (0,0); next pixel is treated as frame start; any pending window is dropped.

Decomposition:
- Shared package img_pkg: IMG_W, IMG_H, DW, COL_W=9, ROW_W=8, WIN_PER_FRAME=75684.
- One sub-module, line_buffer: IMG_W x (2*DW) single-port sync RAM with read-before-write, storing {lbB,lbA} per column.
- window_3x3_gen holds the counters, 3x3 shift registers, output register and handshake.

Test Plan:
- First window: ramp frame pix=(r*320+c) mod 256, win_ready_i=1 -> first win_valid_o one cycle after accepting (2,2), win_o_0..8 = 0,1,2,64,65,66,128,129,130, win_row_o=1, win_col_o=1.
- Window count: full frame streamed, no stalls -> exactly 75684 valid windows, 318 per row, none while c<2 or r<2, frame_done_o single pulse after pixel (239,319).
- Backpressure: hold win_ready_i=0 for 5 cycles mid-row -> pix_ready_o=0, win_o_* and win_col_o unchanged throughout; release -> stream resumes with no lost or duplicated pixel (window sequence matches golden model).
- Row boundary: at accept (3,0) and (3,1) -> no win_valid_o. Next window at (3,2) has taps from cols 0..2 of rows 1..3 (e.g. win_o_0 = (320+0) mod 256 = 64).
- Reset mid-frame: rst_i low at pixel (100,50) -> win_valid_o=0 immediately (async). New ramp frame after release -> first window identical to the first-window scenario.
- Back-to-back frames: two frames, second with pix=255-((r*320+c) mod 256) -> first window of frame 2 appears after its (2,2) with win_o_0=255, and no window mixes frame-1 rows.
